// File: rtl/spi_ram_slave_p_if.sv
// Serial RAM port bundle: slave select, data in/out and frame status.
// The slave modport is used by the RAM; the master modport is used by whatever drives the link.
interface spi_ram_slave_p_if;
    logic SS_n;
    logic MOSI;
    logic MISO;
    logic busy;
    logic frame_done;
    logic frame_err;

    modport slave  (input SS_n, MOSI, output MISO, busy, frame_done, frame_err);
    modport master (output SS_n, MOSI, input MISO, busy, frame_done, frame_err);
endinterface

// File: rtl/spi_ram_slave_p.sv
// Bit-serial RAM slave: 2-bit command then address/data payload, one bit per clk, MSB first.
// Read data appears on MISO one turnaround cycle after the command; no backpressure, SS_n high aborts.
module spi_ram_slave_p #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int AUTO_INC   = 0
) (
    input  logic              clk,
    input  logic              rst,
    spi_ram_slave_p_if.slave  spi
);
    localparam int SW    = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
    localparam int CW    = $clog2(SW + 1);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE, START, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SW-1:0]           shift_q, shift_d;
    logic                    cmd_hi_q, cmd_hi_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic                    armed_q, armed_d;
    logic                    miso_q, miso_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic [SW-1:0]           shift_in;
    logic                    framed;

    assign mem_rdata = mem[rd_addr_q];
    assign shift_in  = {shift_q[SW-2:0], spi.MOSI};
    assign framed    = (state_q != IDLE) && (state_q != HOLD);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        cmd_hi_d  = cmd_hi_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        // A frame may only start once SS_n has been seen high after reset.
        armed_d   = armed_q | spi.SS_n;
        miso_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = shift_in[DATA_WIDTH-1:0];

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                shift_d = '0;
                if (!spi.SS_n && armed_q) state_d = START;
            end
            START: begin
                cnt_d   = '0;
                state_d = CMD;
            end
            CMD: begin
                if (cnt_q == '0) begin
                    cmd_hi_d = spi.MOSI;
                    cnt_d    = CW'(1);
                end else begin
                    cnt_d   = '0;
                    shift_d = '0;
                    case ({cmd_hi_q, spi.MOSI})
                        2'b00:   state_d = WR_ADDR;
                        2'b01:   state_d = WR_DATA;
                        2'b10:   state_d = RD_ADDR;
                        default: state_d = RD_DATA;
                    endcase
                end
            end
            WR_ADDR, RD_ADDR: begin
                shift_d = shift_in;
                if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
                    if (state_q == WR_ADDR) wr_addr_d = shift_in[ADDR_WIDTH-1:0];
                    else                    rd_addr_d = shift_in[ADDR_WIDTH-1:0];
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WR_DATA: begin
                shift_d = shift_in;
                if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    mem_we  = 1'b1;
                    if (AUTO_INC != 0) wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RD_DATA: begin
                // cnt 0 is the turnaround cycle; cnt 1..DATA_WIDTH shift out.
                if (cnt_q == '0) begin
                    shift_d = SW'(mem_rdata);
                    cnt_d   = CW'(1);
                end else begin
                    miso_d  = shift_q[DATA_WIDTH-1];
                    shift_d = shift_q << 1;
                    if (cnt_q == CW'(DATA_WIDTH)) begin
                        if (AUTO_INC != 0) rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (spi.SS_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // SS_n rising before completion drops the frame without side effects.
        if (framed && spi.SS_n) begin
            state_d   = IDLE;
            cnt_d     = '0;
            shift_d   = '0;
            wr_addr_d = wr_addr_q;
            rd_addr_d = rd_addr_q;
            mem_we    = 1'b0;
            miso_d    = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            cmd_hi_q  <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            armed_q   <= 1'b0;
            miso_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            cmd_hi_q  <= cmd_hi_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            armed_q   <= armed_d;
            miso_q    <= miso_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Storage is deliberately outside reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[wr_addr_q] <= mem_wdata;
    end

    assign spi.MISO       = miso_q;
    assign spi.busy       = (state_q != IDLE);
    assign spi.frame_done = done_q;
    assign spi.frame_err  = err_q;
endmodule

// File: tb/tb_spi_ram_slave_p.sv
// Bench for spi_ram_slave_p: three configurations driven bit-by-bit from one directed sequence,
// read data checked against a memory model through an expected-value queue.
module tb_spi_ram_slave_p;
    logic clk;
    logic rst;
    logic [2:0] ss_n;
    logic [2:0] mosi;
    logic [2:0] miso_w, busy_w, done_w, err_w;

    int checks   = 0;
    int failures = 0;
    int done_cnt [3];
    int err_cnt  [3];

    logic [15:0] model [3][256];
    int model_wa [3];
    int model_ra [3];
    int aw   [3] = '{8, 8, 4};
    int dw   [3] = '{8, 8, 16};
    int ainc [3] = '{0, 1, 0};
    logic [31:0] exp_q [$];

    spi_ram_slave_p_if if0 ();
    spi_ram_slave_p_if if1 ();
    spi_ram_slave_p_if if2 ();

    assign if0.SS_n = ss_n[0];  assign if0.MOSI = mosi[0];
    assign if1.SS_n = ss_n[1];  assign if1.MOSI = mosi[1];
    assign if2.SS_n = ss_n[2];  assign if2.MOSI = mosi[2];
    assign miso_w = {if2.MISO, if1.MISO, if0.MISO};
    assign busy_w = {if2.busy, if1.busy, if0.busy};
    assign done_w = {if2.frame_done, if1.frame_done, if0.frame_done};
    assign err_w  = {if2.frame_err, if1.frame_err, if0.frame_err};

    spi_ram_slave_p #(.DATA_WIDTH(8),  .ADDR_WIDTH(8), .AUTO_INC(0)) u0 (.clk(clk), .rst(rst), .spi(if0));
    spi_ram_slave_p #(.DATA_WIDTH(8),  .ADDR_WIDTH(8), .AUTO_INC(1)) u1 (.clk(clk), .rst(rst), .spi(if1));
    spi_ram_slave_p #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .AUTO_INC(0)) u2 (.clk(clk), .rst(rst), .spi(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses are registered; reading them at the next posedge sees the previous cycle's value.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_w[i]) done_cnt[i]++;
            if (err_w[i])  err_cnt[i]++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input int idx, input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi[idx] = val[i];
            tick();
        end
    endtask

    task automatic start_frame(input int idx, input logic [1:0] cmd);
        ss_n[idx] = 1'b0;
        mosi[idx] = 1'b1;
        tick();
        check("busy_in_start", 32'(busy_w[idx]), 32'd1);
        tick();
        send_bits(idx, 32'(cmd), 2);
    endtask

    task automatic end_frame(input int idx);
        ss_n[idx] = 1'b1;
        tick();
        tick();
    endtask

    task automatic write_addr(input int idx, input logic [31:0] a);
        model_wa[idx] = int'(a);
        start_frame(idx, 2'b00);
        send_bits(idx, a, aw[idx]);
        end_frame(idx);
    endtask

    task automatic read_addr(input int idx, input logic [31:0] a);
        model_ra[idx] = int'(a);
        start_frame(idx, 2'b10);
        send_bits(idx, a, aw[idx]);
        end_frame(idx);
    endtask

    task automatic write_data(input int idx, input logic [31:0] d);
        model[idx][model_wa[idx]] = d[15:0];
        if (ainc[idx] != 0) model_wa[idx] = (model_wa[idx] + 1) % (1 << aw[idx]);
        start_frame(idx, 2'b01);
        send_bits(idx, d, dw[idx]);
        end_frame(idx);
    endtask

    task automatic read_data(input int idx, input string tag);
        logic [31:0] got;
        logic [31:0] exp;
        exp_q.push_back(32'(model[idx][model_ra[idx]]));
        if (ainc[idx] != 0) model_ra[idx] = (model_ra[idx] + 1) % (1 << aw[idx]);
        start_frame(idx, 2'b11);
        mosi[idx] = 1'($urandom_range(0, 1));
        tick();
        check({tag, "_turnaround"}, 32'(miso_w[idx]), 32'd0);
        got = '0;
        for (int i = dw[idx] - 1; i >= 0; i--) begin
            mosi[idx] = 1'($urandom_range(0, 1));
            tick();
            got[i] = miso_w[idx];
        end
        exp = exp_q.pop_front();
        check(tag, got, exp);
        end_frame(idx);
        check({tag, "_miso_idle"}, 32'(miso_w[idx]), 32'd0);
    endtask

    initial begin
        int d0;
        int e0;
        rst  = 1'b1;
        ss_n = 3'b000;
        mosi = 3'b000;
        for (int i = 0; i < 3; i++) begin
            model_wa[i] = 0;
            model_ra[i] = 0;
        end
        tick(); tick(); tick();
        check("rst_busy",       32'(busy_w),  32'd0);
        check("rst_miso",       32'(miso_w),  32'd0);
        check("rst_done",       32'(done_w),  32'd0);
        check("rst_err",        32'(err_w),   32'd0);
        check("rst_wr_addr",    32'(u0.wr_addr_q), 32'd0);
        check("rst_rd_addr",    32'(u0.rd_addr_q), 32'd0);

        // SS_n still low after reset: must not start until seen high.
        rst = 1'b0;
        tick(); tick(); tick();
        check("no_start_unarmed", 32'(busy_w), 32'd0);
        ss_n = 3'b111;
        tick(); tick();

        // Write/read round trip with default parameters.
        d0 = done_cnt[0];
        e0 = err_cnt[0];
        write_addr(0, 32'h3C);
        write_data(0, 32'hA5);
        read_addr(0, 32'h3C);
        read_data(0, "rd_3c_a5");
        check("four_done",  32'(done_cnt[0] - d0), 32'd4);
        check("no_err",     32'(err_cnt[0] - e0),  32'd0);
        check("rd_addr_3c", 32'(u0.rd_addr_q), 32'h3C);
        write_addr(0, 32'h00);
        write_data(0, 32'h5A);
        read_addr(0, 32'h00);
        read_data(0, "rd_00_5a");
        check("wr_addr_no_inc", 32'(u0.wr_addr_q), 32'h00);

        // Abort mid-payload after 5 data bits.
        write_addr(0, 32'h10);
        write_data(0, 32'h77);
        e0 = err_cnt[0];
        d0 = done_cnt[0];
        start_frame(0, 2'b01);
        send_bits(0, 32'h1F, 5);
        ss_n[0] = 1'b1;
        tick();
        check("abort_err_pulse", 32'(err_w[0]),  32'd1);
        check("abort_busy",      32'(busy_w[0]), 32'd0);
        tick();
        check("abort_err_single", 32'(err_w[0]), 32'd0);
        tick();
        check("abort_err_cnt",  32'(err_cnt[0] - e0),  32'd1);
        check("abort_no_done",  32'(done_cnt[0] - d0), 32'd0);
        check("abort_wr_addr",  32'(u0.wr_addr_q), 32'h10);
        read_addr(0, 32'h10);
        read_data(0, "rd_after_abort");

        // Abort inside the command field.
        e0 = err_cnt[0];
        ss_n[0] = 1'b0;
        tick(); tick();
        mosi[0] = 1'b1;
        tick();
        ss_n[0] = 1'b1;
        tick();
        tick();
        check("cmd_abort_err", 32'(err_cnt[0] - e0), 32'd1);

        // Extra bits after payload are ignored in HOLD.
        write_addr(0, 32'h20);
        d0 = done_cnt[0];
        e0 = err_cnt[0];
        model[0][32'h20] = 16'hC3;
        start_frame(0, 2'b01);
        send_bits(0, 32'hC3, 8);
        send_bits(0, 32'hF, 4);
        ss_n[0] = 1'b1;
        tick();
        check("hold_exit_idle", 32'(busy_w[0]), 32'd0);
        tick();
        check("hold_one_done", 32'(done_cnt[0] - d0), 32'd1);
        check("hold_no_err",   32'(err_cnt[0] - e0),  32'd0);
        read_addr(0, 32'h20);
        read_data(0, "rd_hold_payload");

        // Reset during the 4th read shift cycle.
        read_addr(0, 32'h3C);
        start_frame(0, 2'b11);
        tick();
        tick(); tick(); tick();
        rst  = 1'b1;
        ss_n = 3'b111;
        tick();
        check("midrst_miso",    32'(miso_w[0]), 32'd0);
        check("midrst_busy",    32'(busy_w[0]), 32'd0);
        check("midrst_wr_addr", 32'(u0.wr_addr_q), 32'd0);
        check("midrst_rd_addr", 32'(u0.rd_addr_q), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            model_wa[i] = 0;
            model_ra[i] = 0;
        end
        tick(); tick();
        read_addr(0, 32'h3C);
        read_data(0, "rd_after_rst");

        // Auto-increment with address wrap.
        write_addr(1, 32'hFF);
        write_data(1, 32'h11);
        write_data(1, 32'h22);
        check("ainc_wr_addr", 32'(u1.wr_addr_q), 32'h01);
        read_addr(1, 32'hFF);
        read_data(1, "ainc_rd_ff");
        read_data(1, "ainc_rd_00");
        check("ainc_rd_addr", 32'(u1.rd_addr_q), 32'h01);

        // Wide data, narrow address.
        write_addr(2, 32'h9);
        write_data(2, 32'hBEEF);
        read_addr(2, 32'h9);
        read_data(2, "wide_beef");
        check("wide_exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
